pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage pipeline.
- Drives the Stall/Flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC hold.
- Resolves three hazard sources:
  - load-use data hazards;
  - taken branches/jumps resolved in EX;
  - multi-cycle data-memory accesses in MEM, with a timeout watchdog.
- Keeps saturating performance counters for stall and flush cycles.

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/sat_counter.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller:
// FSM states, register-zero constant and the stall/flush bundle.
package pipe_pkg;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_MEMWAIT = 2'd1,
    HZ_FAULT   = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic exmem_flush;
    logic memwb_stall;
    logic memwb_flush;
  } hz_ctl_t;

  function automatic logic reg_hit(
    input logic       uses,
    input logic [4:0] src,
    input logic [4:0] dst
  );
    return uses & (src == dst);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use, EX redirect and
// multi-cycle data memory with timeout watchdog.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IDRegRs,
  input  logic [4:0]       IDRegRt,
  input  logic             IDUsesRs,
  input  logic             IDUsesRt,
  input  logic             IDEXMemRead,
  input  logic [4:0]       IDEXRegRd,
  input  logic             EXBranchTaken,
  input  logic             EXMEMMemRead,
  input  logic             EXMEMMemWrite,
  input  logic             MemReady,
  output logic             PCStall,
  output logic             IFIDStall,
  output logic             IFIDFlush,
  output logic             IDEXStall,
  output logic             IDEXFlush,
  output logic             EXMEMStall,
  output logic             EXMEMFlush,
  output logic             MEMWBStall,
  output logic             MEMWBFlush,
  output logic             MemFault,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  hz_state_e      state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

  logic    mem_req;
  logic    mem_wait;
  logic    load_use;
  logic    pc_stall;
  hz_ctl_t ctl;

  assign mem_req = EXMEMMemRead | EXMEMMemWrite;

  assign load_use = IDEXMemRead
                  & (IDEXRegRd != REG_ZERO)
                  & (reg_hit(IDUsesRs, IDRegRs, IDEXRegRd)
                   | reg_hit(IDUsesRt, IDRegRt, IDEXRegRd));

  // A fault freezes the pipe exactly like an endless memory wait.
  assign mem_wait = (state_q == HZ_FAULT)
                  | (mem_req & ~MemReady);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HZ_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      HZ_RUN: begin
        if (mem_req & ~MemReady) begin
          state_d    = HZ_MEMWAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      HZ_MEMWAIT: begin
        if (MemReady) begin
          state_d    = HZ_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCW'(MEM_TIMEOUT)) begin
          state_d = HZ_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      HZ_FAULT: ;
      default: begin
        state_d    = HZ_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    ctl      = '0;
    pc_stall = 1'b0;
    priority case (1'b1)
      rst: ;
      mem_wait: begin
        pc_stall        = 1'b1;
        ctl.ifid_stall  = 1'b1;
        ctl.idex_stall  = 1'b1;
        ctl.exmem_stall = 1'b1;
        ctl.memwb_flush = 1'b1;
      end
      EXBranchTaken: begin
        ctl.ifid_flush = 1'b1;
        ctl.idex_flush = 1'b1;
      end
      load_use: begin
        pc_stall       = 1'b1;
        ctl.ifid_stall = 1'b1;
        ctl.idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCStall    = pc_stall;
  assign IFIDStall  = ctl.ifid_stall;
  assign IFIDFlush  = ctl.ifid_flush;
  assign IDEXStall  = ctl.idex_stall;
  assign IDEXFlush  = ctl.idex_flush;
  assign EXMEMStall = ctl.exmem_stall;
  assign EXMEMFlush = ctl.exmem_flush;
  assign MEMWBStall = ctl.memwb_stall;
  assign MEMWBFlush = ctl.memwb_flush;
  assign MemFault   = (state_q == HZ_FAULT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_stall),
    .count (StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctl.ifid_flush),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against
// a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_rd = '0;
  logic          uses_rs = 0, uses_rt = 0, ex_ld = 0, br = 0;
  logic          m_rd = 0, m_wr = 0, m_rdy = 0;
  logic          pc_s, ifid_s, ifid_f, idex_s, idex_f;
  logic          exmem_s, exmem_f, memwb_s, memwb_f, fault;
  logic [CW-1:0] scnt, fcnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .IDRegRs       (id_rs),
    .IDRegRt       (id_rt),
    .IDUsesRs      (uses_rs),
    .IDUsesRt      (uses_rt),
    .IDEXMemRead   (ex_ld),
    .IDEXRegRd     (ex_rd),
    .EXBranchTaken (br),
    .EXMEMMemRead  (m_rd),
    .EXMEMMemWrite (m_wr),
    .MemReady      (m_rdy),
    .PCStall       (pc_s),
    .IFIDStall     (ifid_s),
    .IFIDFlush     (ifid_f),
    .IDEXStall     (idex_s),
    .IDEXFlush     (idex_f),
    .EXMEMStall    (exmem_s),
    .EXMEMFlush    (exmem_f),
    .MEMWBStall    (memwb_s),
    .MEMWBFlush    (memwb_f),
    .MemFault      (fault),
    .StallCount    (scnt),
    .FlushCount    (fcnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit md_wait, md_fault;
  int md_wcnt, md_sc, md_fc;
  bit [8:0] exp_ctl;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [8:0] dut_ctl();
    return {pc_s, ifid_s, ifid_f, idex_s, idex_f,
            exmem_s, exmem_f, memwb_s, memwb_f};
  endfunction

  task automatic model_reset();
    md_wait = 0; md_fault = 0; md_wcnt = 0; md_sc = 0; md_fc = 0;
  endtask

  // ctl order: pc, ifid_s, ifid_f, idex_s, idex_f, exmem_s, exmem_f, memwb_s, memwb_f
  task automatic model_eval();
    bit req, lu, frz;
    req = m_rd | m_wr;
    lu  = ex_ld && ex_rd != 0 &&
          ((uses_rs && id_rs == ex_rd) || (uses_rt && id_rt == ex_rd));
    frz = md_fault || (req && !m_rdy);
    if (rst)       exp_ctl = 9'b0;
    else if (frz)  exp_ctl = 9'b110101001;
    else if (br)   exp_ctl = 9'b001010000;
    else if (lu)   exp_ctl = 9'b110010000;
    else           exp_ctl = 9'b0;
  endtask

  task automatic model_clock();
    bit req;
    req = m_rd | m_wr;
    if (exp_ctl[8] && md_sc < CMAX) md_sc++;
    if (exp_ctl[6] && md_fc < CMAX) md_fc++;
    if (md_fault) begin
    end else if (!md_wait) begin
      if (req && !m_rdy) begin md_wait = 1; md_wcnt = 1; end
    end else if (m_rdy) begin
      md_wait = 0; md_wcnt = 0;
    end else if (md_wcnt == TO) begin
      md_fault = 1;
    end else begin
      md_wcnt++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    check("ctl",   32'(dut_ctl()), 32'(exp_ctl));
    check("fault", 32'(fault), 32'(md_fault));
    check("scnt",  32'(scnt), 32'(md_sc));
    check("fcnt",  32'(fcnt), 32'(md_fc));
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic set_in(input int rs, input int rt, input bit urs,
                        input bit urt, input bit ld, input int rd,
                        input bit b, input bit mr, input bit mw,
                        input bit rdy);
    id_rs = 5'(rs); id_rt = 5'(rt); uses_rs = urs; uses_rt = urt;
    ex_ld = ld; ex_rd = 5'(rd); br = b;
    m_rd = mr; m_wr = mw; m_rdy = rdy;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // async pulse in the middle of a cycle, released after the edge
  task automatic reset_async();
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("rst_ctl",   32'(dut_ctl()), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_scnt",  32'(scnt), 32'd0);
    check("rst_fcnt",  32'(fcnt), 32'd0);
    @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  initial begin
    model_reset();
    #2;
    check("por_ctl",   32'(dut_ctl()), 32'd0);
    check("por_fault", 32'(fault), 32'd0);
    @(posedge clk);
    #1 rst = 0;

    // load-use, then register zero never stalls
    set_in(5, 0, 1, 0, 1, 5, 0, 0, 0, 1); step();
    check("lu_scnt", 32'(scnt), 32'd1);
    set_in(0, 0, 1, 0, 1, 0, 0, 0, 0, 1); step();
    set_in(3, 7, 0, 1, 1, 7, 0, 0, 0, 1); step();

    // branch overrides load-use
    set_in(5, 0, 1, 0, 1, 5, 1, 0, 0, 1); step();
    check("br_scnt", 32'(scnt), 32'd2);
    check("br_fcnt", 32'(fcnt), 32'd1);

    // 3-cycle memory wait
    reset_async();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1); step();
    check("mw_scnt", 32'(scnt), 32'd3);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); step();
    check("mw_same", 32'(scnt), 32'd3);

    // freeze beats branch, branch applies once memory is ready
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 1, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 1, 1); step();
    check("mwbr_f", 32'(fcnt), 32'd1);

    // timeout into sticky fault
    idle(); step();
    for (int i = 0; i < TO + 1; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    end
    check("to_fault", 32'(fault), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1); step();
    idle(); step();
    check("to_stick", 32'(fault), 32'd1);
    reset_async();
    idle(); step();

    // saturation of the stall counter
    for (int i = 0; i < 10; i++) begin
      set_in(2, 0, 1, 0, 1, 2, 0, 0, 0, 1); step();
    end
    check("sat_scnt", 32'(scnt), 32'(CMAX));

    // randomized traffic
    reset_async();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(99) == 0) reset_async();
      set_in($urandom_range(3), $urandom_range(3),
             1'($urandom), 1'($urandom),
             $urandom_range(2) == 0, $urandom_range(3),
             $urandom_range(5) == 0,
             $urandom_range(3) == 0, $urandom_range(5) == 0,
             $urandom_range(9) < 6);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
